// File: rtl/cam_pkg.sv
// -----------------------------------------------------------------------------
// cam_pkg
// Shared definitions for the camera capture path and the downstream frame
// sender: capture state encoding, default output geometry, and the frame size
// in bytes that both sides agree on.
// -----------------------------------------------------------------------------
package cam_pkg;

   // Capture state machine encoding. Kept as plain constants so older blocks
   // that compare against raw 2-bit codes keep working.
   typedef logic [1:0] state_t;

   localparam state_t ST_IDLE    = 2'd0;
   localparam state_t ST_WAIT_VS = 2'd1;
   localparam state_t ST_CAPTURE = 2'd2;
   localparam state_t ST_DONE    = 2'd3;

   // Default decimated frame geometry and RAM addressing.
   localparam int DEF_OUT_W  = 96;
   localparam int DEF_OUT_H  = 96;
   localparam int DEF_ADDR_W = 15;

   // Bytes in one complete decimated frame; the sender streams exactly this many.
   localparam int FRAME_BYTES = DEF_OUT_W * DEF_OUT_H;

endpackage : cam_pkg

// File: rtl/cam_sync_edge.sv
// -----------------------------------------------------------------------------
// cam_sync_edge
// Brings one asynchronous camera signal into the Clk domain through two flops,
// then compares against a third flop to produce single-cycle rise/fall strobes.
//
// Ports:
//   Clk      in   system clock
//   i_Rst_n  in   asynchronous active-low reset
//   i_Async  in   asynchronous input
//   o_Sync   out  synchronized level
//   o_Rise   out  one-cycle strobe on a synchronized 0->1 transition
//   o_Fall   out  one-cycle strobe on a synchronized 1->0 transition
// -----------------------------------------------------------------------------
module cam_sync_edge (
   input  logic Clk,
   input  logic i_Rst_n,
   input  logic i_Async,
   output logic o_Sync,
   output logic o_Rise,
   output logic o_Fall
);

   logic meta_reg;
   logic sync_reg;
   logic prev_reg;

   always_ff @(posedge Clk or negedge i_Rst_n) begin
      if (!i_Rst_n) begin
         meta_reg <= 1'b0;
         sync_reg <= 1'b0;
         prev_reg <= 1'b0;
      end else begin
         meta_reg <= i_Async;
         sync_reg <= meta_reg;
         prev_reg <= sync_reg;
      end
   end

   assign o_Sync = sync_reg;
   assign o_Rise = sync_reg & ~prev_reg;
   assign o_Fall = ~sync_reg & prev_reg;

endmodule : cam_sync_edge

// File: rtl/cam_frame_capture.sv
// -----------------------------------------------------------------------------
// cam_frame_capture
// Generates the camera master clock, samples the camera parallel bus in the
// Clk domain, decimates one armed frame down to OUT_W x OUT_H bytes (one byte
// per pixel) and writes them sequentially into the frame RAM. o_Frame_Done
// pulses once the RAM holds the frame (or a short frame ended early).
//
// Ports:
//   Clk           in   system clock
//   i_Rst_n       in   asynchronous active-low reset
//   i_D[7:0]      in   camera data bus
//   i_PLK         in   camera pixel clock (asynchronous)
//   i_VS          in   vertical sync, high during blanking
//   i_HS          in   HREF, high while line data is valid
//   i_Arm         in   level request to capture the next full frame
//   o_XLK         out  camera master clock, toggles every XLK_HALF cycles
//   o_Wr_En       out  one-cycle RAM write strobe
//   o_Wr_Addr     out  RAM write address
//   o_Wr_Data     out  RAM write data
//   o_Frame_Done  out  one-cycle pulse, frame complete
//   o_Short       out  frame ended before OUT_W*OUT_H bytes were written
//   o_Busy        out  capture armed or in progress
// -----------------------------------------------------------------------------
module cam_frame_capture
   import cam_pkg::*;
#(
   parameter int XLK_HALF     = 5,
   parameter int BYTES_PER_PX = 2,
   parameter int BYTE_SEL     = 1,
   parameter int H_DEC        = 3,
   parameter int V_DEC        = 2,
   parameter int OUT_W        = DEF_OUT_W,
   parameter int OUT_H        = DEF_OUT_H,
   parameter int ADDR_W       = DEF_ADDR_W
) (
   input  logic              Clk,
   input  logic              i_Rst_n,
   input  logic [7:0]        i_D,
   input  logic              i_PLK,
   input  logic              i_VS,
   input  logic              i_HS,
   input  logic              i_Arm,
   output logic              o_XLK,
   output logic              o_Wr_En,
   output logic [ADDR_W-1:0] o_Wr_Addr,
   output logic [7:0]        o_Wr_Data,
   output logic              o_Frame_Done,
   output logic              o_Short,
   output logic              o_Busy
);

   // ---------------------------------------------------------------- widths
   localparam int XW  = $clog2(XLK_HALF + 1);
   localparam int BW  = $clog2(BYTES_PER_PX + 1);
   localparam int HPW = $clog2(H_DEC + 1);
   localparam int VPW = $clog2(V_DEC + 1);
   localparam int HIW = $clog2(OUT_W + 1);
   localparam int VIW = $clog2(OUT_H + 1);

   localparam logic [XW-1:0]     XLK_LAST   = XW'(XLK_HALF - 1);
   localparam logic [BW-1:0]     BYTE_LAST  = BW'(BYTES_PER_PX - 1);
   localparam logic [BW-1:0]     BYTE_KEEP  = BW'(BYTE_SEL);
   localparam logic [HPW-1:0]    H_LAST     = HPW'(H_DEC - 1);
   localparam logic [VPW-1:0]    V_LAST     = VPW'(V_DEC - 1);
   localparam logic [HIW-1:0]    H_IDX_MAX  = HIW'(OUT_W);
   localparam logic [VIW-1:0]    V_IDX_MAX  = VIW'(OUT_H);
   localparam logic [ADDR_W-1:0] ADDR_LAST  = ADDR_W'(OUT_W * OUT_H - 1);

   // ------------------------------------------------------- master clock
   logic [XW-1:0] xlk_cnt_reg;

   always_ff @(posedge Clk or negedge i_Rst_n) begin
      if (!i_Rst_n) begin
         xlk_cnt_reg <= '0;
         o_XLK       <= 1'b0;
      end else if (xlk_cnt_reg == XLK_LAST) begin
         xlk_cnt_reg <= '0;
         o_XLK       <= ~o_XLK;
      end else begin
         xlk_cnt_reg <= xlk_cnt_reg + 1'b1;
      end
   end

   // --------------------------------------------------- input conditioning
   // Index 0 = PLK, 1 = VS, 2 = HS.
   logic [2:0] raw_in;
   logic [2:0] sync_vec;
   logic [2:0] rise_vec;
   logic [2:0] fall_vec;

   assign raw_in = {i_HS, i_VS, i_PLK};

   genvar gi;
   generate
      for (gi = 0; gi < 3; gi++) begin : g_sync
         cam_sync_edge u_sync (
            .Clk     (Clk),
            .i_Rst_n (i_Rst_n),
            .i_Async (raw_in[gi]),
            .o_Sync  (sync_vec[gi]),
            .o_Rise  (rise_vec[gi]),
            .o_Fall  (fall_vec[gi])
         );
      end
   endgenerate

   logic plk_rise;
   logic vs_rise;
   logic vs_fall;
   logic hs_sync;
   logic hs_fall;

   assign plk_rise = rise_vec[0];
   assign vs_rise  = rise_vec[1];
   assign vs_fall  = fall_vec[1];
   assign hs_sync  = sync_vec[2];
   assign hs_fall  = fall_vec[2];

   // Edge/level outputs this block has no use for.
   logic unused_edges;
   assign unused_edges = &{1'b0, sync_vec[1:0], fall_vec[0], rise_vec[2]};

   // Data goes through the same two-flop depth as PLK so that, on plk_rise,
   // d_dly2_reg holds the byte that was on the bus at the pixel clock edge.
   logic [7:0] d_dly1_reg;
   logic [7:0] d_dly2_reg;

   always_ff @(posedge Clk or negedge i_Rst_n) begin
      if (!i_Rst_n) begin
         d_dly1_reg <= '0;
         d_dly2_reg <= '0;
      end else begin
         d_dly1_reg <= i_D;
         d_dly2_reg <= d_dly1_reg;
      end
   end

   // -------------------------------------------------------------- counters
   // Pixel and line positions are kept as (index, phase) pairs so the
   // decimation tests need no dividers: px_cnt = px_idx*H_DEC + px_ph and
   // line_cnt = line_idx*V_DEC + line_ph. The index saturates at the output
   // size, which is enough to block any further keeps on long lines/frames.
   state_t          state_reg;
   logic            vs_seen_reg;
   logic [BW-1:0]   byte_cnt_reg;
   logic [HPW-1:0]  px_ph_reg;
   logic [HIW-1:0]  px_idx_reg;
   logic [VPW-1:0]  line_ph_reg;
   logic [VIW-1:0]  line_idx_reg;
   logic [ADDR_W-1:0] addr_reg;

   logic frame_start;
   logic keep;

   assign frame_start = (state_reg == ST_WAIT_VS) && vs_seen_reg && vs_fall;

   assign keep = (state_reg == ST_CAPTURE) && plk_rise && hs_sync
              && (byte_cnt_reg == BYTE_KEEP)
              && (px_ph_reg == '0)   && (px_idx_reg < H_IDX_MAX)
              && (line_ph_reg == '0) && (line_idx_reg < V_IDX_MAX);

   always_ff @(posedge Clk or negedge i_Rst_n) begin
      if (!i_Rst_n) begin
         byte_cnt_reg <= '0;
         px_ph_reg    <= '0;
         px_idx_reg   <= '0;
         line_ph_reg  <= '0;
         line_idx_reg <= '0;
      end else if (frame_start) begin
         byte_cnt_reg <= '0;
         px_ph_reg    <= '0;
         px_idx_reg   <= '0;
         line_ph_reg  <= '0;
         line_idx_reg <= '0;
      end else if (hs_fall) begin
         byte_cnt_reg <= '0;
         px_ph_reg    <= '0;
         px_idx_reg   <= '0;
         if (line_ph_reg == V_LAST) begin
            line_ph_reg <= '0;
            if (line_idx_reg != V_IDX_MAX)
               line_idx_reg <= line_idx_reg + 1'b1;
         end else begin
            line_ph_reg <= line_ph_reg + 1'b1;
         end
      end else if (plk_rise && hs_sync) begin
         if (byte_cnt_reg == BYTE_LAST) begin
            byte_cnt_reg <= '0;
            if (px_ph_reg == H_LAST) begin
               px_ph_reg <= '0;
               if (px_idx_reg != H_IDX_MAX)
                  px_idx_reg <= px_idx_reg + 1'b1;
            end else begin
               px_ph_reg <= px_ph_reg + 1'b1;
            end
         end else begin
            byte_cnt_reg <= byte_cnt_reg + 1'b1;
         end
      end
   end

   // --------------------------------------------------------- state machine
   always_ff @(posedge Clk or negedge i_Rst_n) begin
      if (!i_Rst_n) begin
         state_reg    <= ST_IDLE;
         vs_seen_reg  <= 1'b0;
         addr_reg     <= '0;
         o_Wr_En      <= 1'b0;
         o_Wr_Addr    <= '0;
         o_Wr_Data    <= '0;
         o_Frame_Done <= 1'b0;
         o_Short      <= 1'b0;
         o_Busy       <= 1'b0;
      end else begin
         o_Wr_En      <= 1'b0;
         o_Frame_Done <= 1'b0;
         o_Busy       <= (state_reg == ST_WAIT_VS) || (state_reg == ST_CAPTURE);

         case (state_reg)
            ST_IDLE: begin
               vs_seen_reg <= 1'b0;
               if (i_Arm)
                  state_reg <= ST_WAIT_VS;
            end

            // A rise must be seen first so a frame already running at arm
            // time is skipped; its end (rise) precedes our frame's start (fall).
            ST_WAIT_VS: begin
               if (!vs_seen_reg) begin
                  if (vs_rise)
                     vs_seen_reg <= 1'b1;
               end else if (vs_fall) begin
                  vs_seen_reg <= 1'b0;
                  addr_reg    <= '0;
                  o_Short     <= 1'b0;
                  state_reg   <= ST_CAPTURE;
               end
            end

            // The address holds at the last location rather than advancing,
            // so it can never run past the frame.
            ST_CAPTURE: begin
               if (keep) begin
                  o_Wr_En   <= 1'b1;
                  o_Wr_Addr <= addr_reg;
                  o_Wr_Data <= d_dly2_reg;
                  if (addr_reg == ADDR_LAST)
                     state_reg <= ST_DONE;
                  else
                     addr_reg <= addr_reg + 1'b1;
               end else if (vs_rise) begin
                  o_Short   <= 1'b1;
                  state_reg <= ST_DONE;
               end
            end

            ST_DONE: begin
               o_Frame_Done <= 1'b1;
               state_reg    <= ST_IDLE;
            end

            default: state_reg <= ST_IDLE;
         endcase
      end
   end

endmodule : cam_frame_capture

// File: tb/tb_cam_frame_capture.sv
// -----------------------------------------------------------------------------
// tb_cam_frame_capture
// Directed bench for cam_frame_capture with a reduced frame geometry
// (6x6 output from an 18 px x 12 line camera, 2 bytes/px) so every scenario
// fits in a short run. Camera byte 1 of pixel p on line l is p^l, byte 0 is
// its complement, so the kept byte for output index k is (3*(k%6))^(2*(k/6)).
// -----------------------------------------------------------------------------
module tb_cam_frame_capture;

   localparam int TB_OUT_W  = 6;
   localparam int TB_OUT_H  = 6;
   localparam int TB_H_DEC  = 3;
   localparam int TB_V_DEC  = 2;
   localparam int TB_FRAME  = TB_OUT_W * TB_OUT_H;   // 36
   localparam int CAM_PX    = 18;
   localparam int BUDGET    = 12000;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [7:0]  cam_d;
   logic        cam_plk;
   logic        cam_vs;
   logic        cam_hs;
   logic        arm;
   logic        xlk;
   logic        wr_en;
   logic [14:0] wr_addr;
   logic [7:0]  wr_data;
   logic        frame_done;
   logic        short_f;
   logic        busy;

   always #4 clk = ~clk;

   cam_frame_capture #(
      .XLK_HALF     (5),
      .BYTES_PER_PX (2),
      .BYTE_SEL     (1),
      .H_DEC        (TB_H_DEC),
      .V_DEC        (TB_V_DEC),
      .OUT_W        (TB_OUT_W),
      .OUT_H        (TB_OUT_H),
      .ADDR_W       (15)
   ) dut (
      .Clk          (clk),
      .i_Rst_n      (rst_n),
      .i_D          (cam_d),
      .i_PLK        (cam_plk),
      .i_VS         (cam_vs),
      .i_HS         (cam_hs),
      .i_Arm        (arm),
      .o_XLK        (xlk),
      .o_Wr_En      (wr_en),
      .o_Wr_Addr    (wr_addr),
      .o_Wr_Data    (wr_data),
      .o_Frame_Done (frame_done),
      .o_Short      (short_f),
      .o_Busy       (busy)
   );

   // ------------------------------------------------------------ camera model
   int cam_lines = 12;
   int cam_frame = 0;
   int cam_line  = 0;
   int cam_px    = 0;

   initial begin : camera
      int n_lines;
      logic [7:0] v;
      cam_plk = 1'b0;
      cam_vs  = 1'b1;
      cam_hs  = 1'b0;
      cam_d   = 8'h00;
      forever begin
         cam_vs = 1'b1;
         repeat (24) @(negedge clk);
         cam_vs  = 1'b0;
         n_lines = cam_lines;
         cam_frame++;
         repeat (12) @(negedge clk);
         for (int l = 0; l < n_lines; l++) begin
            cam_line = l;
            for (int p = 0; p < CAM_PX; p++) begin
               cam_px = p;
               v = 8'(p ^ l);
               for (int b = 0; b < 2; b++) begin
                  cam_plk = 1'b0;
                  cam_hs  = 1'b1;
                  cam_d   = (b == 1) ? v : ~v;
                  repeat (4) @(negedge clk);
                  cam_plk = 1'b1;
                  repeat (4) @(negedge clk);
               end
            end
            cam_plk = 1'b0;
            cam_hs  = 1'b0;
            repeat (12) @(negedge clk);
         end
      end
   end

   // ------------------------------------------------------------ bookkeeping
   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int wr_count = 0;
   int cap_base = 0;
   int done_count = 0;
   int last_short = 0;
   int first_frame = 0;
   int cyc_last_wr = 0;
   int cyc_done    = 0;
   logic prev_xlk  = 1'b0;
   int xlk_toggles[$];

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] exp_data(input int k);
      int c;
      int r;
      c = k % TB_OUT_W;
      r = k / TB_OUT_W;
      return 8'((c * TB_H_DEC) ^ (r * TB_V_DEC));
   endfunction

   // Advance one clock and sample outputs just after the edge.
   task automatic step();
      int k;
      @(posedge clk);
      #1;
      cyc++;
      if (xlk !== prev_xlk) xlk_toggles.push_back(cyc);
      prev_xlk = xlk;
      if (wr_en === 1'b1) begin
         k = wr_count - cap_base;
         if (wr_count == cap_base) first_frame = cam_frame;
         $display("wr addr=%0d data=%02h (frame %0d)", wr_addr, wr_data, cam_frame);
         check_eq("wr_addr", 32'(wr_addr), 32'(k));
         check_eq("wr_data", 32'(wr_data), 32'(exp_data(k)));
         wr_count++;
         cyc_last_wr = cyc;
      end
      if (frame_done === 1'b1) begin
         done_count++;
         last_short = int'(short_f);
         cyc_done   = cyc;
         $display("frame_done short=%0b writes=%0d", short_f, wr_count - cap_base);
      end
   endtask

   task automatic wait_done(input string tag);
      int d0;
      int n;
      d0 = done_count;
      n  = 0;
      while (done_count == d0 && n < BUDGET) begin
         step();
         n++;
      end
      check_eq(tag, 32'(done_count - d0), 32'd1);
   endtask

   // ------------------------------------------------------------------ tests
   initial begin : main
      int n;
      int arm_frame;
      int d0;
      int w0;

      rst_n = 1'b0;
      arm   = 1'b1;   // armed throughout reset: must still not write

      // Reset with the camera running.
      repeat (200) step();
      check_eq("rst_outputs", {xlk, wr_en, wr_addr, wr_data, frame_done, short_f, busy}, 32'd0);
      check_eq("rst_no_writes", 32'(wr_count), 32'd0);
      arm = 1'b0;
      rst_n = 1'b1;
      xlk_toggles.delete();
      repeat (30) step();
      check_eq("xlk_toggled", 32'(xlk_toggles.size() >= 3), 32'd1);
      if (xlk_toggles.size() >= 3) begin
         check_eq("xlk_half0", 32'(xlk_toggles[1] - xlk_toggles[0]), 32'd5);
         check_eq("xlk_half1", 32'(xlk_toggles[2] - xlk_toggles[1]), 32'd5);
      end

      // Full frame.
      cap_base = wr_count;
      arm = 1'b1;
      wait_done("full_done");
      arm = 1'b0;
      check_eq("full_writes", 32'(wr_count - cap_base), TB_FRAME);
      check_eq("full_short", 32'(last_short), 32'd0);
      check_eq("full_done_lat", 32'(cyc_done - cyc_last_wr), 32'd1);
      check_eq("full_busy_low", 32'(busy), 32'd0);

      // Arm in the middle of a line of a running frame.
      n = 0;
      while (!(cam_line == 5 && cam_px == 9) && n < BUDGET) begin
         step();
         n++;
      end
      check_eq("midline_reached", 32'(cam_line == 5 && cam_px == 9), 32'd1);
      cap_base  = wr_count;
      arm_frame = cam_frame;
      arm = 1'b1;
      step();
      step();
      check_eq("mid_busy", 32'(busy), 32'd1);
      wait_done("mid_done");
      arm = 1'b0;
      check_eq("mid_frame_id", 32'(first_frame), 32'(arm_frame + 1));
      check_eq("mid_writes", 32'(wr_count - cap_base), TB_FRAME);
      check_eq("mid_short", 32'(last_short), 32'd0);

      // Short frame: 7 lines keep lines 0,2,4,6 -> 24 bytes.
      cam_lines = 7;
      cap_base = wr_count;
      arm = 1'b1;
      wait_done("short_done");
      arm = 1'b0;
      cam_lines = 12;
      check_eq("short_writes", 32'(wr_count - cap_base), 32'd24);
      check_eq("short_flag", 32'(last_short), 32'd1);
      repeat (10) step();
      check_eq("short_held", 32'(short_f), 32'd1);

      // Arm for a single cycle: exactly one frame, then idle.
      cap_base = wr_count;
      arm = 1'b1;
      step();
      arm = 1'b0;
      wait_done("drop_done");
      check_eq("drop_writes", 32'(wr_count - cap_base), TB_FRAME);
      check_eq("drop_short", 32'(last_short), 32'd0);
      d0 = done_count;
      w0 = wr_count;
      repeat (8000) step();
      check_eq("drop_no_done", 32'(done_count - d0), 32'd0);
      check_eq("drop_no_write", 32'(wr_count - w0), 32'd0);
      check_eq("drop_idle", 32'(busy), 32'd0);

      // Reset in the middle of a capture.
      cap_base = wr_count;
      arm = 1'b1;
      n = 0;
      while ((wr_count - cap_base) < 21 && n < BUDGET) begin
         step();
         n++;
      end
      check_eq("midrst_reached", 32'(wr_count - cap_base), 32'd21);
      #2;
      rst_n = 1'b0;
      #1;
      check_eq("midrst_outputs", {xlk, wr_en, wr_addr, wr_data, frame_done, short_f, busy}, 32'd0);
      w0 = wr_count;
      repeat (20) step();
      check_eq("midrst_quiet", 32'(wr_count - w0), 32'd0);
      cap_base = wr_count;
      rst_n = 1'b1;
      wait_done("restart_done");
      arm = 1'b0;
      check_eq("restart_writes", 32'(wr_count - cap_base), TB_FRAME);
      check_eq("restart_short", 32'(last_short), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule : tb_cam_frame_capture
